// File: rtl/pipe_collide_fsm_if.sv
// ---------------------------------------------------------------------------
// pipe_collide_fsm_if
//
// Purpose: this bus links the collision/game-control stage with two blocks:
// the pipe X-coordinate store and the pipe gap Y ROM. The signals are grouped
// here so the three blocks share one definition.
//
// Signals:
//   pipe_x    [9:0]  left edge of the in-scope pipe (from the X store)
//   out_pipe  [1:0]  index of the in-scope pipe (from the X store)
//   y_addr    [1:0]  Y ROM address (driven by the game-control stage)
//   y_data    [8:0]  gap top Y from the synchronous ROM. It is valid one
//                    cycle after y_addr.
//   count_EN         pipe scroll enable to the X store
//   game_rst         one-cycle active-high restart to the X store and bird
//
// Modports:
//   master  the game-control stage (pipe_collide_fsm)
//   slave   the X store / ROM side
// ---------------------------------------------------------------------------
interface pipe_collide_fsm_if;
    logic [9:0] pipe_x;
    logic [1:0] out_pipe;
    logic [1:0] y_addr;
    logic [8:0] y_data;
    logic       count_EN;
    logic       game_rst;

    modport master (
        input  pipe_x,
        input  out_pipe,
        input  y_data,
        output y_addr,
        output count_EN,
        output game_rst
    );

    modport slave (
        output pipe_x,
        output out_pipe,
        output y_data,
        input  y_addr,
        input  count_EN,
        input  game_rst
    );
endinterface

// File: rtl/pipe_collide_fsm.sv
// ---------------------------------------------------------------------------
// pipe_collide_fsm
//
// Purpose: this block consumes the in-scope pipe from the X store. It looks up
// the gap of that pipe in the Y ROM and checks the bird against three things:
// the pipe body, the gap and the floor. It also runs the play-state machine,
// which scrolls the pipes, steps the bird physics, flags a loss and issues
// the restart pulse.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   start       one-cycle flap/start pulse (debounced upstream)
//   frame_tick  one-cycle pulse per video frame
//   bird_y      bird top edge, 0..479
//   fall_EN     registered bird-physics step enable
//   Lose        registered, sticky loss flag
//   pipe_bus    master side of pipe_collide_fsm_if. It carries these signals:
//               pipe_x, out_pipe, y_addr, y_data, count_EN and game_rst.
//
// Timing: pipe_x and bird_y are registered once (stage 1). The ROM registers
// y_addr on the same edge, so y_data lines up with stage 1. The compare logic
// is combinational on stage 1. The FSM acts on the result at the next edge.
// Inputs that are present before edge k therefore affect Lose after
// edge k+1.
// ---------------------------------------------------------------------------
module pipe_collide_fsm #(
    parameter int unsigned BIRD_X  = 320,
    parameter int unsigned BIRD_W  = 16,
    parameter int unsigned BIRD_H  = 16,
    parameter int unsigned PIPE_W  = 80,
    parameter int unsigned GAP_H   = 120,
    parameter int unsigned FLOOR_Y = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   frame_tick,
    input  logic [8:0]             bird_y,
    output logic                   fall_EN,
    output logic                   Lose,
    pipe_collide_fsm_if.master     pipe_bus
);

    // All geometry is evaluated on 11 bits. The sums stay below 2048, so
    // no compare can wrap.
    localparam logic [10:0] BIRD_X_C  = 11'(BIRD_X);
    localparam logic [10:0] BIRD_W_C  = 11'(BIRD_W);
    localparam logic [10:0] BIRD_H_C  = 11'(BIRD_H);
    localparam logic [10:0] PIPE_W_C  = 11'(PIPE_W);
    localparam logic [10:0] GAP_H_C   = 11'(GAP_H);
    localparam logic [10:0] FLOOR_Y_C = 11'(FLOOR_Y);

    typedef enum logic [1:0] {
        READY = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t     state_reg;

    // Stage-1 pipeline registers
    logic [9:0] x_s1_reg;
    logic [8:0] by_s1_reg;
    logic       v_s1_reg;

    // Registered outputs
    logic       count_en_reg;
    logic       fall_en_reg;
    logic       lose_reg;
    logic       game_rst_reg;

    // Compare results
    logic [10:0] x_ext;
    logic [10:0] by_ext;
    logic [10:0] yd_ext;
    logic [10:0] live_by_ext;
    logic        h_ovl;
    logic        v_out;
    logic        floor_s1;
    logic        floor_live;
    logic        hit;

    // The ROM address follows the in-scope pipe with no delay. The
    // synchronous ROM supplies the register stage.
    assign pipe_bus.y_addr = pipe_bus.out_pipe;

    // ------------------------------------------------------------------
    // Stage 1
    // v_s1 records whether the sampled data belongs to live play. The
    // first cycle after READY->PLAY therefore sees v_s1=0, and stale
    // pipe/bird data cannot score a hit. Leaving OVER also clears v_s1,
    // because the state at that edge is not PLAY.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_s1_reg  <= '0;
            by_s1_reg <= '0;
            v_s1_reg  <= 1'b0;
        end else begin
            x_s1_reg  <= pipe_bus.pipe_x;
            by_s1_reg <= bird_y;
            v_s1_reg  <= (state_reg == PLAY);
        end
    end

    // ------------------------------------------------------------------
    // Collision compare on stage 1
    // h_ovl: the pipe column [x, x+PIPE_W) overlaps the bird column
    //        [BIRD_X, BIRD_X+BIRD_W).
    // v_out: the bird is not fully inside the gap [y_data, y_data+GAP_H].
    // ------------------------------------------------------------------
    assign x_ext       = {1'b0, x_s1_reg};
    assign by_ext      = {2'b00, by_s1_reg};
    assign yd_ext      = {2'b00, pipe_bus.y_data};
    assign live_by_ext = {2'b00, bird_y};

    assign h_ovl      = (x_ext < (BIRD_X_C + BIRD_W_C)) &&
                        ((x_ext + PIPE_W_C) > BIRD_X_C);
    assign v_out      = (by_ext < yd_ext) ||
                        ((by_ext + BIRD_H_C) > (yd_ext + GAP_H_C));
    assign floor_s1   = (by_ext + BIRD_H_C) >= FLOOR_Y_C;
    assign hit        = v_s1_reg && ((h_ovl && v_out) || floor_s1);

    // While DYING the bird keeps falling. It is tested against the floor
    // directly from the live input, because stage-1 validity no longer
    // matters once the game is lost.
    assign floor_live = (live_by_ext + BIRD_H_C) >= FLOOR_Y_C;

    // ------------------------------------------------------------------
    // Play-state machine with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= READY;
            count_en_reg <= 1'b0;
            fall_en_reg  <= 1'b0;
            lose_reg     <= 1'b0;
            game_rst_reg <= 1'b0;
        end else begin
            game_rst_reg <= 1'b0;
            unique case (state_reg)
                READY: begin
                    count_en_reg <= 1'b0;
                    fall_en_reg  <= 1'b0;
                    if (start) begin
                        state_reg <= PLAY;
                    end
                end

                PLAY: begin
                    // A losing frame must not scroll. If it did, the score
                    // would advance on the frame where the bird crashed.
                    count_en_reg <= frame_tick && !hit;
                    fall_en_reg  <= frame_tick;
                    if (hit) begin
                        lose_reg  <= 1'b1;
                        state_reg <= floor_s1 ? OVER : DYING;
                    end
                end

                DYING: begin
                    count_en_reg <= 1'b0;
                    fall_en_reg  <= frame_tick;
                    if (floor_live) begin
                        state_reg <= OVER;
                    end
                end

                OVER: begin
                    count_en_reg <= 1'b0;
                    fall_en_reg  <= 1'b0;
                    if (start) begin
                        game_rst_reg <= 1'b1;
                        lose_reg     <= 1'b0;
                        state_reg    <= READY;
                    end
                end

                default: begin
                    state_reg    <= READY;
                    count_en_reg <= 1'b0;
                    fall_en_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign pipe_bus.count_EN = count_en_reg;
    assign pipe_bus.game_rst = game_rst_reg;
    assign fall_EN           = fall_en_reg;
    assign Lose              = lose_reg;

endmodule

// File: tb/tb_pipe_collide_fsm.sv
// ---------------------------------------------------------------------------
// tb_pipe_collide_fsm
//
// The bench runs a directed walk through the game scenarios and then a
// randomized soak. A behavioural reference model follows the game. The model
// checks collisions as rectangle overlap on integers. A negedge scoreboard
// compares every DUT output with the model on every cycle. The directed
// scenarios also check key points against fixed expected values.
// ---------------------------------------------------------------------------
module tb_pipe_collide_fsm;

    localparam int BX = 320, BW = 16, BH = 16, PW = 80, GH = 120, FY = 480;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic [8:0] bird_y = '0;
    logic       fall_EN;
    logic       Lose;

    pipe_collide_fsm_if bus ();

    logic [8:0] rom [4];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit sb_en = 1'b0;

    pipe_collide_fsm #(
        .BIRD_X(BX), .BIRD_W(BW), .BIRD_H(BH),
        .PIPE_W(PW), .GAP_H(GH), .FLOOR_Y(FY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .frame_tick(frame_tick),
        .bird_y    (bird_y),
        .fall_EN   (fall_EN),
        .Lose      (Lose),
        .pipe_bus  (bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous Y ROM: the address is registered by the read
    always @(posedge clk) bus.y_data <= rom[bus.y_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_READY, M_PLAY, M_DYING, M_OVER} phase_t;
    phase_t phase;
    int     m_x, m_by;
    bit     m_live;
    bit     exp_count, exp_fall, exp_lose, exp_grst;

    // The bird box [BX,BX+BW) x [by,by+BH) must either miss the pipe
    // column or sit fully inside the gap [gy, gy+GH].
    function automatic bit pipe_crash(int px, int by, int gy);
        int lo, hi;
        lo = (px > BX) ? px : BX;
        hi = (px + PW < BX + BW) ? px + PW : BX + BW;
        if (lo >= hi) return 1'b0;
        return !((by >= gy) && (by + BH <= gy + GH));
    endfunction

    function automatic bit grounded(int by);
        return (by + BH) >= FY;
    endfunction

    function automatic bit crashed(bit live, int px, int by, int gy);
        return live && (pipe_crash(px, by, gy) || grounded(by));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= M_READY;
            exp_count <= 0; exp_fall <= 0; exp_lose <= 0; exp_grst <= 0;
            m_x <= 0; m_by <= 0; m_live <= 0;
        end else begin
            m_x    <= int'(bus.pipe_x);
            m_by   <= int'(bird_y);
            m_live <= (phase == M_PLAY);
            exp_grst <= 0;
            case (phase)
                M_READY: begin
                    exp_count <= 0; exp_fall <= 0;
                    if (start) phase <= M_PLAY;
                end
                M_PLAY: begin
                    exp_fall  <= frame_tick;
                    exp_count <= frame_tick && !crashed(m_live, m_x, m_by, int'(bus.y_data));
                    if (crashed(m_live, m_x, m_by, int'(bus.y_data))) begin
                        exp_lose <= 1;
                        phase <= grounded(m_by) ? M_OVER : M_DYING;
                    end
                end
                M_DYING: begin
                    exp_count <= 0; exp_fall <= frame_tick;
                    if (grounded(int'(bird_y))) phase <= M_OVER;
                end
                M_OVER: begin
                    exp_count <= 0; exp_fall <= 0;
                    if (start) begin
                        exp_grst <= 1; exp_lose <= 0; phase <= M_READY;
                    end
                end
            endcase
        end
    end

    // Scoreboard: every output is compared once per cycle, away from the edge
    always @(negedge clk) begin
        if (sb_en) begin
            check_eq("sb_count_EN", bus.count_EN, exp_count);
            check_eq("sb_fall_EN", fall_EN, exp_fall);
            check_eq("sb_Lose", Lose, exp_lose);
            check_eq("sb_game_rst", bus.game_rst, exp_grst);
            check_eq("sb_y_addr", bus.y_addr, bus.out_pipe);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc_step();
        @(posedge clk);
        #1;
        cyc++;
        frame_tick = (cyc % 8 == 0);
    endtask

    task automatic run(input int n);
        repeat (n) cyc_step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc_step();
        start = 1'b0;
    endtask

    int px_list  [4] = '{240, 241, 335, 336};
    bit hit_list [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        for (int i = 0; i < 4; i++) rom[i] = 9'd200;
        bus.pipe_x = 10'd600;
        bus.out_pipe = 2'd0;
        bird_y = 9'd250;

        // 1: reset, start, normal play
        run(3);
        sb_en = 1'b1;
        check_eq("rst_Lose", Lose, 0);
        check_eq("rst_count_EN", bus.count_EN, 0);
        check_eq("rst_fall_EN", fall_EN, 0);
        check_eq("rst_game_rst", bus.game_rst, 0);
        reset = 1'b1;
        run(2);
        pulse_start();
        run(10);
        for (int i = 0; i < 8 && !frame_tick; i++) cyc_step();
        cyc_step();
        check_eq("tick_count_EN", bus.count_EN, 1);
        check_eq("tick_fall_EN", fall_EN, 1);
        cyc_step();
        check_eq("post_tick_count_EN", bus.count_EN, 0);
        check_eq("play_Lose", Lose, 0);
        $display("scenario play: checks=%0d errors=%0d", n_checks, n_errors);

        // 2: inside gap, then above gap -> DYING; ramp to floor with starts ignored
        bus.pipe_x = 10'd300;
        run(4);
        check_eq("gap_ok_Lose", Lose, 0);
        bird_y = 9'd190;
        run(2);
        check_eq("gap_hit_Lose", Lose, 1);
        run(10);
        check_eq("dying_count_EN", bus.count_EN, 0);
        for (int by = 200; by <= 470; by += 10) begin
            bird_y = 9'(by);
            start = (by % 20 == 0);
            cyc_step();
            start = 1'b0;
        end
        run(2);
        check_eq("over_Lose", Lose, 1);
        check_eq("over_fall_EN", fall_EN, 0);
        pulse_start();
        check_eq("restart_game_rst", bus.game_rst, 1);
        check_eq("restart_Lose", Lose, 0);
        cyc_step();
        check_eq("restart_game_rst_end", bus.game_rst, 0);
        $display("scenario dying: checks=%0d errors=%0d", n_checks, n_errors);

        // 3: horizontal boundary
        for (int k = 0; k < 4; k++) begin
            bird_y = 9'd100;
            bus.pipe_x = 10'(px_list[k]);
            pulse_start();
            run(2);
            check_eq($sformatf("hbound_%0d_Lose", px_list[k]), Lose, 32'(hit_list[k]));
            bird_y = 9'd470;
            run(3);
            check_eq($sformatf("hbound_%0d_over", px_list[k]), Lose, 1);
            pulse_start();
            run(1);
        end
        $display("scenario hbound: checks=%0d errors=%0d", n_checks, n_errors);

        // 4: floor straight from PLAY -> OVER
        bus.pipe_x = 10'd600;
        bird_y = 9'd250;
        pulse_start();
        run(4);
        bird_y = 9'd464;
        run(2);
        check_eq("floor_Lose", Lose, 1);
        for (int i = 0; i < 10; i++) begin
            cyc_step();
            check_eq("floor_fall_EN_stop", fall_EN, 0);
        end
        pulse_start();
        check_eq("floor_game_rst", bus.game_rst, 1);
        cyc_step();
        check_eq("floor_game_rst_end", bus.game_rst, 0);
        check_eq("floor_ready_Lose", Lose, 0);
        $display("scenario floor: checks=%0d errors=%0d", n_checks, n_errors);

        // 5: a hit on the same cycle as frame_tick must not scroll
        bus.pipe_x = 10'd300;
        bird_y = 9'd250;
        pulse_start();
        run(3);
        for (int i = 0; i < 8 && (cyc % 8) != 7; i++) cyc_step();
        bird_y = 9'd190;
        cyc_step();
        cyc_step();
        check_eq("coinc_count_EN", bus.count_EN, 0);
        check_eq("coinc_fall_EN", fall_EN, 1);
        check_eq("coinc_Lose", Lose, 1);
        $display("scenario coincident: checks=%0d errors=%0d", n_checks, n_errors);

        // 6: async reset while DYING
        run(3);
        reset = 1'b0;
        #1;
        check_eq("async_Lose", Lose, 0);
        check_eq("async_count_EN", bus.count_EN, 0);
        check_eq("async_fall_EN", fall_EN, 0);
        #2;
        reset = 1'b1;
        run(2);
        bird_y = 9'd464;
        run(4);
        check_eq("after_reset_ready_Lose", Lose, 0);
        $display("scenario async_reset: checks=%0d errors=%0d", n_checks, n_errors);

        // 7: randomized soak
        for (int i = 0; i < 4; i++) rom[i] = 9'($urandom_range(0, 359));
        for (int i = 0; i < 3000; i++) begin
            bus.out_pipe = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus.pipe_x = 10'($urandom_range(0, 1023));
            else                           bus.pipe_x = 10'($urandom_range(230, 345));
            bird_y = 9'($urandom_range(0, 479));
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                cyc_step();
                reset = 1'b1;
            end
            cyc_step();
            start = 1'b0;
            if (i % 1000 == 999)
                $display("random batch %0d: checks=%0d errors=%0d", i / 1000, n_checks, n_errors);
        end

        sb_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_collide_fsm.md
Name: pipe_collide_fsm

Overview:
- Downstream consumer of the pipe X-coordinate store; also the game-control stage that drives it.
- Takes the in-scope pipe's left-edge X and index, fetches that pipe's gap Y from the Y ROM, and checks the bird against pipe, gap and floor.
- Runs the play-state machine, which produces count_EN (pipe scroll enable), Lose, the bird-fall enable and the restart pulse.

Parameters:
- BIRD_X, 320, bird left edge (pixels)
- BIRD_W, 16, bird width
- BIRD_H, 16, bird height
- PIPE_W, 80, pipe width
- GAP_H, 120, vertical gap height
- FLOOR_Y, 480, floor line; the bird touches the floor when bird_y+BIRD_H >= FLOOR_Y

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle flap/start pulse (debounced upstream)
- frame_tick  in  1  one-cycle pulse per video frame
- pipe_x  in  10  in-scope pipe left edge (from X store Output)
- out_pipe  in  2  in-scope pipe index
- bird_y  in  9  bird top edge, 0..479
- y_addr  out  2  Y ROM address; combinational, equal to out_pipe
- y_data  in  9  gap top Y from the synchronous ROM, valid one cycle after y_addr
- count_EN  out  1  registered scroll enable to the X store
- fall_EN  out  1  registered bird-physics step enable
- Lose  out  1  registered, sticky loss flag
- game_rst  out  1  registered one-cycle active-high restart for the X store and bird

Behaviour:
- Reset (reset=0, async):
  - state=READY.
  - count_EN=0, fall_EN=0, Lose=0, game_rst=0.
  - Pipeline registers cleared; valid=0.
- Stage 1 (every edge):
  - x_s1<=pipe_x, by_s1<=bird_y, v_s1<=(state==PLAY).
  - The ROM captures y_addr on the same edge, so y_data is aligned with stage 1.
- Compare (combinational on stage 1, all arithmetic 11-bit unsigned, no wrap):
  - h_ovl = (x_s1 < BIRD_X+BIRD_W) && (x_s1+PIPE_W > BIRD_X).
  - v_out = (by_s1 < y_data) || (by_s1+BIRD_H > y_data+GAP_H).
  - floor = (by_s1+BIRD_H >= FLOOR_Y).
  - hit = v_s1 && ((h_ovl && v_out) || floor).
- Latency: inputs present before edge k cause Lose=1 after edge k+1.
- States:
  - READY: count_EN=0, fall_EN=0. On start -> PLAY.
  - PLAY:
    - count_EN<=frame_tick && !hit; fall_EN<=frame_tick.
    - On hit: Lose<=1. Go to OVER if floor, else DYING.
  - DYING:
    - count_EN<=0; fall_EN<=frame_tick; start is ignored.
    - Floor test uses the live bird_y (not the v_s1-gated hit): when bird_y+BIRD_H >= FLOOR_Y -> OVER.
  - OVER:
    - count_EN=0, fall_EN=0, Lose held 1.
    - On start: game_rst<=1 for exactly one cycle, Lose<=0, valid pipeline flushed -> READY.
- Simultaneous events:
  - hit and frame_tick in the same cycle: no count_EN, so the score is not incremented by a scroll on a losing frame.
  - start in PLAY: ignored.
  - start and floor in DYING: floor wins.
- v_s1 gating: the cycle after READY->PLAY has v_s1=0, so no false hit from stale data.
- Mid-game reset: all outputs return to reset values immediately (async). The rest of the design gets no game_rst pulse; the X store resets from the system reset.
- Lose never deasserts except via reset or OVER->READY.

Test Plan:
- Reset low, then release, start pulse, frame_tick every 8 cycles, pipe_x=600, bird_y=250, y_data=200 -> PLAY; count_EN and fall_EN pulse one cycle after each tick; Lose=0.
- pipe_x=300, y_data=200, bird_y=250 (bird 250..266 inside gap 200..320) -> no hit. Set bird_y=190 -> Lose=1 two edges later, state DYING, count_EN stays 0 on the next tick.
- Horizontal boundary, bird_y=100, y_data=200: pipe_x=240 -> no hit (240+80 not > 320); pipe_x=241 -> hit; pipe_x=335 -> hit; pipe_x=336 -> no hit.
- In PLAY, bird_y=464 (464+16=480) -> direct PLAY->OVER, Lose=1, fall_EN stops. Then start -> game_rst high for exactly 1 cycle, Lose=0, READY.
- Hit coincident with frame_tick -> count_EN not asserted for that tick. From DYING, bird_y ramps to 470 -> OVER when bird_y>=464; start pulses during DYING are ignored.
- Assert reset during DYING -> Lose and count_EN go 0 asynchronously, before the next clk edge; state READY after release.
